// File: rtl/poly_reduce_seq_if.sv
// Handshake bundle for poly_reduce_seq: product input stream and reduced-result output stream.
interface poly_reduce_seq_if #(
  parameter int W = 8,
  parameter int N = 5
);
  logic                   in_valid;
  logic                   in_ready;
  logic [(2*N-1)*W-1:0]   in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N*W-1:0]         out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/poly_reduce_seq.sv
// Sequential reduction of a (2N-1)-coefficient product modulo f(x) = x^N + x^K + 1, mod-2^W coefficients.
// Optional 16-bit transfer counter output op_count when POLY_REDUCE_COUNT_EN is defined.
module poly_reduce_seq #(
  parameter int W = 8,
  parameter int N = 5,
  parameter int K = 2
) (
  input  logic               clk,
  input  logic               reset,
  poly_reduce_seq_if.slave   bus
`ifdef POLY_REDUCE_COUNT_EN
  ,
  output logic [15:0]        op_count
`endif
);

  localparam int M  = 2*N - 1;
  localparam int IW = $clog2(M);
  localparam logic [IW-1:0] IDX_TOP = IW'(M - 1);
  localparam logic [IW-1:0] IDX_END = IW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    w [M];
  logic            in_ready_q;
  logic            out_valid_q;

  // Fold targets for the current top term: x^idx = -x^(idx-N+K) - x^(idx-N)
  logic [IW-1:0]   lo_idx;
  logic [IW-1:0]   mid_idx;
  logic [W-1:0]    top_val;

  always_comb begin
    lo_idx  = idx - IW'(N);
    mid_idx = idx - IW'(N - K);
    top_val = w[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= IDX_TOP;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < M; i++) begin
        w[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int unsigned i = 0; i < M; i++) begin
              w[i] <= bus.in_data[i*W +: W];
            end
            idx        <= IDX_TOP;
            state      <= FOLD;
            in_ready_q <= 1'b0;
          end
        end
        FOLD: begin
          // Both subtractions read top_val, the pre-edge value of w[idx]
          for (int unsigned i = 0; i < M; i++) begin
            if (IW'(i) == lo_idx) begin
              w[i] <= w[i] - top_val;
            end else if (IW'(i) == mid_idx) begin
              w[i] <= w[i] - top_val;
            end else if (IW'(i) == idx) begin
              w[i] <= '0;
            end
          end
          if (idx == IDX_END) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  logic [N*W-1:0] out_flat;

  always_comb begin
    out_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      out_flat[i*W +: W] = w[i];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_flat;

`ifdef POLY_REDUCE_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_count <= '0;
    end else if (out_valid_q && bus.out_ready) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_poly_reduce_seq.sv
// Directed self-checking bench for poly_reduce_seq at W=8, N=5, K=2.
module tb_poly_reduce_seq;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  int   xfers;

  poly_reduce_seq_if #(.W(8), .N(5)) if0 ();

`ifdef POLY_REDUCE_COUNT_EN
  logic [15:0] op_count;
`endif

  poly_reduce_seq #(.W(8), .N(5), .K(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (if0)
`ifdef POLY_REDUCE_COUNT_EN
    ,
    .op_count (op_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pack9(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {a8, a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [39:0] pack5(input logic [7:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer din in IDLE, verify exact latency and result, leave the result pending in DONE.
  task automatic run_vec(input string tag, input logic [71:0] din, input logic [39:0] exp);
    @(negedge clk);
    check({tag, "_rdy"}, 64'(if0.in_ready), 64'd1);
    if0.in_valid = 1'b1;
    if0.in_data  = din;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    if0.in_data  = {$urandom, $urandom, $urandom};
    check({tag, "_busy"}, 64'(if0.in_ready), 64'd0);
    for (int e = 1; e < 4; e++) begin
      @(posedge clk);
      #1;
      check({tag, "_early"}, 64'(if0.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(if0.out_valid), 64'd1);
    check({tag, "_data"}, 64'(if0.out_data), 64'(exp));
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    if0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.out_ready = 1'b0;
    xfers++;
    check({tag, "_ovdrop"}, 64'(if0.out_valid), 64'd0);
    check({tag, "_idle"}, 64'(if0.in_ready), 64'd1);
  endtask

  initial begin
    logic [39:0] held;
    compared   = 0;
    mismatched = 0;
    xfers      = 0;
    reset         = 1'b0;
    if0.in_valid  = 1'b0;
    if0.in_data   = '0;
    if0.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(if0.in_ready), 64'd1);
    check("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst_out_data", 64'(if0.out_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    run_vec("low_pass", pack9(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0),
            pack5(8'd1, 8'd2, 8'd3, 8'd4, 8'd5));
    release_out("low_pass");

    run_vec("s5", pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0),
            pack5(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00));
    release_out("s5");

    run_vec("s8", pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1),
            pack5(8'h01, 8'h00, 8'h01, 8'hFF, 8'h00));
    release_out("s8");

    run_vec("all_ones", pack9(8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1),
            pack5(8'h01, 8'h00, 8'h00, 8'hFF, 8'h00));
    release_out("all_ones");

    run_vec("s6_s2", pack9(8'd0, 8'd0, 8'h03, 8'd0, 8'd0, 8'd0, 8'h10, 8'd0, 8'd0),
            pack5(8'h00, 8'hF0, 8'h03, 8'hF0, 8'h00));

    // Backpressure: result held, new input offered but refused while in DONE
    held = pack5(8'h00, 8'hF0, 8'h03, 8'hF0, 8'h00);
    @(negedge clk);
    if0.in_valid = 1'b1;
    if0.in_data  = pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("hold_data", 64'(if0.out_data), 64'(held));
      check("hold_nrdy", 64'(if0.in_ready), 64'd0);
      if (c == 5) if0.in_data = pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);
    end
    @(negedge clk);
    if0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if0.out_ready = 1'b0;
    xfers++;
    check("pulse_ovdrop", 64'(if0.out_valid), 64'd0);
    check("pulse_no_accept", 64'(if0.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check("next_accepted", 64'(if0.in_ready), 64'd0);
    for (int e = 1; e < 4; e++) begin
      @(posedge clk);
      #1;
      check("next_early", 64'(if0.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("next_valid", 64'(if0.out_valid), 64'd1);
    check("next_data", 64'(if0.out_data), 64'(pack5(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00)));
    release_out("next");

`ifdef POLY_REDUCE_COUNT_EN
    check("op_count", 64'(op_count), 64'(xfers));
`endif

    // Reset during the second FOLD cycle aborts the operation
    @(negedge clk);
    if0.in_valid = 1'b1;
    if0.in_data  = pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1);
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_rdy", 64'(if0.in_ready), 64'd1);
    check("abort_ov", 64'(if0.out_valid), 64'd0);
    check("abort_data", 64'(if0.out_data), 64'd0);
    @(posedge clk);
    #1;
    check("abort_data2", 64'(if0.out_data), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check("abort_no_ov", 64'(if0.out_valid), 64'd0);
    end

    // First edge after reset release accepts the waiting input
    @(negedge clk);
    reset = 1'b0;
    if0.in_valid = 1'b1;
    if0.in_data  = pack9(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    check("rst_hold_rdy", 64'(if0.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    check("first_accept", 64'(if0.in_ready), 64'd0);
    for (int e = 1; e < 4; e++) begin
      @(posedge clk);
      #1;
      check("first_early", 64'(if0.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check("first_valid", 64'(if0.out_valid), 64'd1);
    check("first_data", 64'(if0.out_data), 64'(pack5(8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00)));
    release_out("first");

`ifdef POLY_REDUCE_COUNT_EN
    check("op_count_post_rst", 64'(op_count), 64'(xfers));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
